regfile_wb_sched: RTL

- Write-back scheduler for the 8x8 register file with two write ports.
- Arbitrates up to three write-back requesters (load unit, ALU, stack unit) onto port M (dstM/M) and port E (dstE/E) using round-robin.
- Registers the winning writes into an output stage.
- Exports a busy scoreboard of registers with writes in flight, so issue logic can stall read-after-write hazards.

---
 rtl/regfile_wb_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of three requesters onto the
// M and E write ports of the 8x8 register file, plus a busy scoreboard.
module regfile_wb_sched #(
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_dst,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [AW-1:0]        dstM,
    output logic [DW-1:0]        M,
    output logic [AW-1:0]        dstE,
    output logic [DW-1:0]        E,
    output logic [(1<<AW)-1:0]   busy,
    output logic [7:0]           conflict_cnt
);

    localparam int NREG = 1 << AW;

    logic [1:0]    r_rr;
    logic [AW-1:0] r_dst_m;
    logic [AW-1:0] r_dst_e;
    logic [DW-1:0] r_m;
    logic [DW-1:0] r_e;
    logic [7:0]    r_cnt;

    logic [NREQ-1:0] w_ready;
    logic            w_m_vld;
    logic            w_e_vld;
    logic [1:0]      w_m_idx;
    logic [1:0]      w_e_idx;
    logic [AW-1:0]   w_m_dst;
    logic [AW-1:0]   w_e_dst;
    logic [DW-1:0]   w_m_data;
    logic [DW-1:0]   w_e_data;
    logic            w_conflict;
    logic [1:0]      w_idx;
    logic [AW-1:0]   w_dst;
    logic [1:0]      w_last;
    logic [1:0]      w_rr_nxt;
    logic [NREG-1:0] w_busy;

    // Modulo-NREQ increment for requester indices.
    function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'(NREQ))
            s = s - 3'(NREQ);
        return s[1:0];
    endfunction

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_ready    = '0;
        w_m_vld    = 1'b0;
        w_e_vld    = 1'b0;
        w_m_idx    = '0;
        w_e_idx    = '0;
        w_m_dst    = '0;
        w_e_dst    = '0;
        w_m_data   = '0;
        w_e_data   = '0;
        w_conflict = 1'b0;
        w_idx      = '0;
        w_dst      = '0;
        if (!hold) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = wrap_add(r_rr, 2'(k));
                w_dst = req_dst[w_idx*AW +: AW];
                if (req_valid[w_idx]) begin
                    if (w_dst == '0) begin
                        // Writes to register 0 are accepted and discarded.
                        w_ready[w_idx] = 1'b1;
                    end else if (!w_m_vld) begin
                        w_ready[w_idx] = 1'b1;
                        w_m_vld        = 1'b1;
                        w_m_idx        = w_idx;
                        w_m_dst        = w_dst;
                        w_m_data       = req_data[w_idx*DW +: DW];
                    end else if (!w_e_vld && (w_dst != w_m_dst)) begin
                        w_ready[w_idx] = 1'b1;
                        w_e_vld        = 1'b1;
                        w_e_idx        = w_idx;
                        w_e_dst        = w_dst;
                        w_e_data       = req_data[w_idx*DW +: DW];
                    end else if (!w_e_vld) begin
                        // Port E was free: deferred purely by the M-port clash.
                        w_conflict = 1'b1;
                    end
                end
            end
        end
        w_last   = w_e_vld ? w_e_idx : w_m_idx;
        w_rr_nxt = wrap_add(w_last, 2'd1);
    end

    // NOTE: the whole output stage, including data, is reset so in-flight
    // writes are dropped and busy clears as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr    <= '0;
            r_dst_m <= '0;
            r_dst_e <= '0;
            r_m     <= '0;
            r_e     <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            r_dst_m <= w_m_vld ? w_m_dst : '0;
            r_dst_e <= w_e_vld ? w_e_dst : '0;
            if (w_m_vld)
                r_m <= w_m_data;
            if (w_e_vld)
                r_e <= w_e_data;
            if (w_m_vld)
                r_rr <= w_rr_nxt;
            if (w_conflict && (r_cnt != 8'hFF))
                r_cnt <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_busy          = '0;
        w_busy[r_dst_m] = 1'b1;
        w_busy[r_dst_e] = 1'b1;
        w_busy[0]       = 1'b0;
    end

    assign req_ready    = w_ready;
    assign dstM         = r_dst_m;
    assign M            = r_m;
    assign dstE         = r_dst_e;
    assign E            = r_e;
    assign busy         = w_busy;
    assign conflict_cnt = r_cnt;

endmodule
